// File: rtl/sha256_digest_serializer.sv
// Serializes a 256-bit SHA-256 digest into eight 32-bit words with valid/ready output handshake.
// Optional macro SHA256_DIGEST_IDX_EN adds word_idx_o carrying the current word index.
module sha256_digest_serializer #(
  parameter int WORD_ORDER = 0
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         v_i,
  input  logic [255:0] digest_i,
  output logic         yumi_o,
  output logic         v_o,
  output logic [31:0]  data_o,
  output logic         last_o,
`ifdef SHA256_DIGEST_IDX_EN
  output logic [2:0]   word_idx_o,
`endif
  input  logic         ready_i
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2:0]     r_cnt;
  logic [255:0]   r_hold;
  logic           w_last;
  logic           w_fire;
  logic           w_accept;
  logic [2:0]     w_sel;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: SEND persists across back-to-back digests
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (v_i) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (ready_i && (r_cnt == 3'd7) && !v_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from state, counter and holding register
  always_comb begin
    w_last   = (r_state == ST_SEND) && (r_cnt == 3'd7);
    w_fire   = (r_state == ST_SEND) && ready_i;
    w_accept = v_i && ((r_state == ST_IDLE) || (w_fire && w_last));
    yumi_o   = w_accept && reset_n_i;
    if (WORD_ORDER != 0) begin
      w_sel = 3'd7 - r_cnt;
    end else begin
      w_sel = r_cnt;
    end
    v_o    = (r_state == ST_SEND);
    last_o = w_last;
    if (r_state == ST_SEND) begin
      data_o = r_hold[{w_sel, 5'd0} +: 32];
    end else begin
      data_o = 32'd0;
    end
`ifdef SHA256_DIGEST_IDX_EN
    if (r_state == ST_SEND) begin
      word_idx_o = r_cnt;
    end else begin
      word_idx_o = 3'd0;
    end
`endif
  end

  // Holding register and word counter; a new capture always restarts at word 0
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_hold <= 256'd0;
      r_cnt  <= 3'd0;
    end else if (w_accept) begin
      r_hold <= digest_i;
      r_cnt  <= 3'd0;
    end else if (w_fire && !w_last) begin
      r_cnt  <= r_cnt + 3'd1;
    end else begin
      r_cnt  <= r_cnt;
    end
  end

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Scoreboard bench: driver pushes expected words per accepted digest, negedge monitor compares two DUTs (both word orders).
module tb_sha256_digest_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n_i;
  logic         v_i;
  logic         ready_i;
  logic [255:0] digest_i;

  logic         yumi0, v0, last0;
  logic [31:0]  data0;
  logic         yumi1, v1, last1;
  logic [31:0]  data1;
`ifdef SHA256_DIGEST_IDX_EN
  logic [2:0]   idx0, idx1;
`endif

  sha256_digest_serializer #(.WORD_ORDER(0)) u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .digest_i(digest_i),
    .yumi_o(yumi0), .v_o(v0), .data_o(data0), .last_o(last0),
`ifdef SHA256_DIGEST_IDX_EN
    .word_idx_o(idx0),
`endif
    .ready_i(ready_i)
  );

  sha256_digest_serializer #(.WORD_ORDER(1)) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .digest_i(digest_i),
    .yumi_o(yumi1), .v_o(v1), .data_o(data1), .last_o(last1),
`ifdef SHA256_DIGEST_IDX_EN
    .word_idx_o(idx1),
`endif
    .ready_i(ready_i)
  );

  localparam logic [255:0] ABC = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                  32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  logic [31:0] abc_words [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                 32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  typedef struct packed {
    logic [255:0] dig;
    logic [2:0]   idx;
  } ent_t;

  ent_t         q[$];
  ent_t         e;
  logic         pend;
  logic [255:0] pend_dig;
  logic         exp_yumi;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [255:0] d, input int i);
    logic [255:0] sh;
    sh = d >> (32 * i);
    return sh[31:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  // Monitor: compare outputs against the head of the scoreboard, pop on handshake
  always @(negedge clk) begin
    check("yumi_o0", {255'd0, yumi0}, {255'd0, exp_yumi});
    check("yumi_o1", {255'd0, yumi1}, {255'd0, exp_yumi});
    if (q.size() == 0) begin
      check("idle_v0", {255'd0, v0}, 256'd0);
      check("idle_v1", {255'd0, v1}, 256'd0);
      check("idle_data0", {224'd0, data0}, 256'd0);
      check("idle_data1", {224'd0, data1}, 256'd0);
      check("idle_last0", {255'd0, last0}, 256'd0);
`ifdef SHA256_DIGEST_IDX_EN
      check("idle_idx0", {253'd0, idx0}, 256'd0);
`endif
    end else begin
      e = q[0];
      check("v0", {255'd0, v0}, 256'd1);
      check("v1", {255'd0, v1}, 256'd1);
      check("data0", {224'd0, data0}, {224'd0, word_of(e.dig, int'(e.idx))});
      check("data1", {224'd0, data1}, {224'd0, word_of(e.dig, 7 - int'(e.idx))});
      check("last0", {255'd0, last0}, {255'd0, (e.idx == 3'd7)});
      check("last1", {255'd0, last1}, {255'd0, (e.idx == 3'd7)});
      if (e.dig == ABC) begin
        check("abc_word", {224'd0, data0}, {224'd0, abc_words[e.idx]});
      end
`ifdef SHA256_DIGEST_IDX_EN
      check("idx0", {253'd0, idx0}, {253'd0, e.idx});
      check("idx1", {253'd0, idx1}, {253'd0, e.idx});
`endif
      if (ready_i) void'(q.pop_front());
    end
  end

  task automatic cycle(input logic v, input logic [255:0] d, input logic rdy, input logic rstn);
    @(posedge clk);
    #1;
    if (pend) begin
      for (int i = 0; i < 8; i++) q.push_back('{dig: pend_dig, idx: 3'(i)});
      pend = 1'b0;
    end
    reset_n_i = rstn;
    if (!rstn) q.delete();
    v_i      = v;
    digest_i = d;
    ready_i  = rdy;
    exp_yumi = rstn && v && ((q.size() == 0) || ((q.size() == 1) && rdy));
    if (exp_yumi) begin
      pend     = 1'b1;
      pend_dig = d;
    end
  endtask

  task automatic reset_now_checks();
    #1;
    check("rst_v0", {255'd0, v0}, 256'd0);
    check("rst_last0", {255'd0, last0}, 256'd0);
    check("rst_data0", {224'd0, data0}, 256'd0);
    check("rst_yumi0", {255'd0, yumi0}, 256'd0);
  endtask

  initial begin
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    ready_i   = 1'b0;
    digest_i  = 256'd0;
    pend      = 1'b0;
    pend_dig  = 256'd0;
    exp_yumi  = 1'b0;
    cycle(1'b1, ABC, 1'b1, 1'b0);
    reset_now_checks();
    cycle(1'b0, 256'd0, 1'b0, 1'b0);

    // "abc" digest with ready held high
    cycle(1'b0, 256'd0, 1'b1, 1'b1);
    cycle(1'b1, ABC, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, rand256(), 1'b1, 1'b1);

    // stall pattern 1,0,0,1,0,0,...
    cycle(1'b1, ABC, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b0, rand256(), (i % 3 == 0), 1'b1);

    // back-to-back digests with v_i held high
    for (int i = 0; i < 17; i++) cycle(1'b1, rand256(), 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, rand256(), 1'b1, 1'b1);

    // reset after the word-3 handshake
    cycle(1'b1, ABC, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, rand256(), 1'b1, 1'b1);
    cycle(1'b1, rand256(), 1'b1, 1'b0);
    reset_now_checks();
    cycle(1'b1, rand256(), 1'b1, 1'b0);
    cycle(1'b1, ABC, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, rand256(), 1'b1, 1'b1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand256(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 199) != 0));
    end

    // drain with a bounded budget
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0 && !pend) break;
      cycle(1'b0, rand256(), 1'b1, 1'b1);
    end
    cycle(1'b0, 256'd0, 1'b1, 1'b1);
    check("drain_empty", 256'(q.size()), 256'd0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
